// File: rtl/reorder_buffer_pkg.sv
// Shared widths, tag encoding and entry layout for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned ENTRY_SIZE = 4;
  localparam int unsigned ROB_SIZE   = 1 << ENTRY_SIZE;
  localparam int unsigned TAG_W      = ENTRY_SIZE + 1;
  localparam int unsigned CNT_W      = ENTRY_SIZE + 1;
  localparam int unsigned REG_W      = 6;
  localparam int unsigned XLEN       = 32;

  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [ENTRY_SIZE-1:0] idx_t;

  localparam tag_t ENTRY_NULL = TAG_W'(0);

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  value;
    logic             is_branch;
    logic             is_store;
    logic             pred_taken;
    logic             actual_taken;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  target;
  } rob_ent_t;

  // Tags are slot index + 1 so that tag 0 can mean "no producer".
  function automatic idx_t tag_to_idx(input tag_t t);
    return ENTRY_SIZE'(t - TAG_W'(1));
  endfunction

  function automatic tag_t idx_to_tag(input idx_t i);
    return TAG_W'(i) + TAG_W'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB, operand-query, commit and flush signals of the reorder buffer.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic             issue_valid;
  logic [REG_W-1:0] issue_rd;
  logic             issue_is_branch;
  logic             issue_is_store;
  logic             issue_pred_taken;
  logic [XLEN-1:0]  issue_pc;
  logic             rob_full;
  logic             new_issue;
  tag_t             rob_new_entry;

  logic             cdb_valid;
  tag_t             cdb_entry;
  logic [XLEN-1:0]  cdb_value;
  logic             cdb_taken;
  logic [XLEN-1:0]  cdb_target;

  tag_t             query_j;
  tag_t             query_k;
  logic             ready_j;
  logic             ready_k;
  logic [XLEN-1:0]  value_j;
  logic [XLEN-1:0]  value_k;

  logic             rob_commit;
  tag_t             rob_entry;
  logic [REG_W-1:0] rob_des;
  logic [XLEN-1:0]  rob_result;
  logic             store_commit;
  logic             roll_back;
  logic [XLEN-1:0]  jump_pc;

  modport slave (
    input  issue_valid, issue_rd, issue_is_branch, issue_is_store, issue_pred_taken, issue_pc,
    input  cdb_valid, cdb_entry, cdb_value, cdb_taken, cdb_target,
    input  query_j, query_k,
    output rob_full, new_issue, rob_new_entry,
    output ready_j, ready_k, value_j, value_k,
    output rob_commit, rob_entry, rob_des, rob_result, store_commit, roll_back, jump_pc
  );

  modport master (
    output issue_valid, issue_rd, issue_is_branch, issue_is_store, issue_pred_taken, issue_pc,
    output cdb_valid, cdb_entry, cdb_value, cdb_taken, cdb_target,
    output query_j, query_k,
    input  rob_full, new_issue, rob_new_entry,
    input  ready_j, ready_k, value_j, value_k,
    input  rob_commit, rob_entry, rob_des, rob_result, store_commit, roll_back, jump_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete via CDB,
// in-order retire with branch-mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  bus
);

  rob_ent_t         ent_q [ROB_SIZE];
  rob_ent_t         ent_d [ROB_SIZE];
  idx_t             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             commit_q, commit_d;
  tag_t             entry_q, entry_d;
  logic [REG_W-1:0] des_q, des_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             store_q, store_d;
  logic             roll_q, roll_d;
  logic [XLEN-1:0]  jump_q, jump_d;

  rob_ent_t         head_ent;
  logic             full_c, accept_c, commit_c, mispred_c, cdb_hit_c;
  idx_t             cdb_idx;
  logic [XLEN:0]    look_j, look_k;

  // Control decisions; nothing moves while paused or in the flush cycle.
  always_comb begin
    head_ent  = ent_q[head_q];
    full_c    = (cnt_q == CNT_W'(ROB_SIZE));
    accept_c  = rdy_in && bus.issue_valid && !full_c && !roll_q;
    commit_c  = rdy_in && (cnt_q != CNT_W'(0)) && head_ent.busy && head_ent.ready;
    mispred_c = commit_c && head_ent.is_branch && (head_ent.actual_taken != head_ent.pred_taken);
    cdb_hit_c = rdy_in && !roll_q && bus.cdb_valid && (bus.cdb_entry != ENTRY_NULL);
    cdb_idx   = tag_to_idx(bus.cdb_entry);
  end

  always_comb begin
    ent_d    = ent_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q + CNT_W'(accept_c) - CNT_W'(commit_c);
    commit_d = commit_c;
    store_d  = commit_c && head_ent.is_store;
    entry_d  = entry_q;
    des_d    = des_q;
    result_d = result_q;
    roll_d   = mispred_c;
    jump_d   = jump_q;

    if (cdb_hit_c && ent_q[cdb_idx].busy) begin
      ent_d[cdb_idx].ready        = 1'b1;
      ent_d[cdb_idx].value        = bus.cdb_value;
      ent_d[cdb_idx].actual_taken = bus.cdb_taken;
      ent_d[cdb_idx].target       = bus.cdb_target;
    end

    if (accept_c) begin
      ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, rd: bus.issue_rd, value: XLEN'(0),
                        is_branch: bus.issue_is_branch, is_store: bus.issue_is_store,
                        pred_taken: bus.issue_pred_taken, actual_taken: 1'b0,
                        pc: bus.issue_pc, target: XLEN'(0)};
      tail_d = tail_q + idx_t'(1);
    end

    if (commit_c) begin
      ent_d[head_q].busy  = 1'b0;
      ent_d[head_q].ready = 1'b0;
      head_d   = head_q + idx_t'(1);
      entry_d  = idx_to_tag(head_q);
      des_d    = head_ent.rd;
      result_d = head_ent.value;
    end

    // Mispredict squashes everything younger, including a same-cycle issue.
    if (mispred_c) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_d[i].busy  = 1'b0;
        ent_d[i].ready = 1'b0;
      end
      head_d = idx_t'(0);
      tail_d = idx_t'(0);
      cnt_d  = CNT_W'(0);
      jump_d = head_ent.actual_taken ? head_ent.target : head_ent.pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      entry_q  <= '0;
      des_q    <= '0;
      result_q <= '0;
      store_q  <= 1'b0;
      roll_q   <= 1'b0;
      jump_q   <= '0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= ent_d[i];
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      entry_q  <= entry_d;
      des_q    <= des_d;
      result_q <= result_d;
      store_q  <= store_d;
      roll_q   <= roll_d;
      jump_q   <= jump_d;
    end
  end

  // Operand lookup: tag 0 is an immediate zero, CDB forward beats stored value.
  function automatic logic [XLEN:0] lookup(input tag_t q, input logic cv, input tag_t ce,
                                           input logic [XLEN-1:0] cval,
                                           input logic e_rdy, input logic [XLEN-1:0] e_val);
    if (q == ENTRY_NULL)        return {1'b1, XLEN'(0)};
    if (cv && (ce == q))        return {1'b1, cval};
    if (e_rdy)                  return {1'b1, e_val};
    return '0;
  endfunction

  always_comb begin
    look_j = lookup(bus.query_j, bus.cdb_valid, bus.cdb_entry, bus.cdb_value,
                    ent_q[tag_to_idx(bus.query_j)].busy && ent_q[tag_to_idx(bus.query_j)].ready,
                    ent_q[tag_to_idx(bus.query_j)].value);
    look_k = lookup(bus.query_k, bus.cdb_valid, bus.cdb_entry, bus.cdb_value,
                    ent_q[tag_to_idx(bus.query_k)].busy && ent_q[tag_to_idx(bus.query_k)].ready,
                    ent_q[tag_to_idx(bus.query_k)].value);
  end

  assign bus.ready_j       = look_j[XLEN];
  assign bus.value_j       = look_j[XLEN-1:0];
  assign bus.ready_k       = look_k[XLEN];
  assign bus.value_k       = look_k[XLEN-1:0];
  assign bus.rob_full      = full_c;
  assign bus.new_issue     = accept_c;
  assign bus.rob_new_entry = idx_to_tag(tail_q);
  assign bus.rob_commit    = commit_q;
  assign bus.rob_entry     = entry_q;
  assign bus.rob_des       = des_q;
  assign bus.rob_result    = result_q;
  assign bus.store_commit  = store_q;
  assign bus.roll_back     = roll_q;
  assign bus.jump_pc       = jump_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: operand-query vector table plus
// hand-written issue/commit/flush/pause sequences.
module tb_reorder_buffer;

  logic clk;
  logic rst_in;
  logic rdy_in;
  int   total;
  int   bad;

  reorder_buffer_if bus();

  reorder_buffer dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [4:0]  qj;
    logic [4:0]  qk;
    logic        cv;
    logic [4:0]  ce;
    logic [31:0] cval;
    logic        rj;
    logic [31:0] vj;
    logic        rk;
    logic [31:0] vk;
  } qvec_t;

  qvec_t qv [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid      = 1'b0;
    bus.issue_rd         = '0;
    bus.issue_is_branch  = 1'b0;
    bus.issue_is_store   = 1'b0;
    bus.issue_pred_taken = 1'b0;
    bus.issue_pc         = '0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_entry        = '0;
    bus.cdb_value        = '0;
    bus.cdb_taken        = 1'b0;
    bus.cdb_target       = '0;
    bus.query_j          = '0;
    bus.query_k          = '0;
  endtask

  task automatic issue(input logic [5:0] rd, input logic br, input logic st,
                       input logic pred, input logic [31:0] pc);
    bus.issue_valid      = 1'b1;
    bus.issue_rd         = rd;
    bus.issue_is_branch  = br;
    bus.issue_is_store   = st;
    bus.issue_pred_taken = pred;
    bus.issue_pc         = pc;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val,
                     input logic taken, input logic [31:0] tgt);
    bus.cdb_valid  = 1'b1;
    bus.cdb_entry  = tag;
    bus.cdb_value  = val;
    bus.cdb_taken  = taken;
    bus.cdb_target = tgt;
  endtask

  task automatic reset_dut();
    idle();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    clk   = 1'b0;
    total = 0;
    bad   = 0;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();

    qv[0] = '{5'd4, 5'd0, 1'b1, 5'd4, 32'hAA, 1'b1, 32'hAA, 1'b1, 32'h0};
    qv[1] = '{5'd2, 5'd3, 1'b0, 5'd0, 32'h0,  1'b1, 32'h55, 1'b0, 32'h0};
    qv[2] = '{5'd3, 5'd2, 1'b1, 5'd3, 32'h77, 1'b1, 32'h77, 1'b1, 32'h55};
    qv[3] = '{5'd2, 5'd4, 1'b1, 5'd2, 32'h99, 1'b1, 32'h99, 1'b0, 32'h0};
    qv[4] = '{5'd1, 5'd1, 1'b1, 5'd0, 32'hFF, 1'b0, 32'h0,  1'b0, 32'h0};
    qv[5] = '{5'd0, 5'd5, 1'b0, 5'd0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0};
    qv[6] = '{5'd4, 5'd4, 1'b0, 5'd4, 32'hAB, 1'b0, 32'h0,  1'b0, 32'h0};

    // Reset state
    reset_dut();
    chk("rst_full", bus.rob_full, 0);
    chk("rst_commit", bus.rob_commit, 0);
    chk("rst_roll_back", bus.roll_back, 0);
    chk("rst_jump_pc", bus.jump_pc, 0);
    chk("rst_new_entry", bus.rob_new_entry, 1);
    chk("rst_result", bus.rob_result, 0);
    chk("rst_new_issue", bus.new_issue, 0);

    // Single issue, complete, commit
    issue(6'd5, 0, 0, 0, 32'h0);
    #1;
    chk("t1_new_issue", bus.new_issue, 1);
    chk("t1_tag", bus.rob_new_entry, 1);
    tick();
    idle();
    cdb(5'd1, 32'h1234, 0, 0);
    tick();
    idle();
    #1;
    chk("t1_no_early_commit", bus.rob_commit, 0);
    tick();
    chk("t1_commit", bus.rob_commit, 1);
    chk("t1_entry", bus.rob_entry, 1);
    chk("t1_des", bus.rob_des, 5);
    chk("t1_result", bus.rob_result, 32'h1234);
    chk("t1_store", bus.store_commit, 0);
    tick();
    chk("t1_commit_pulse", bus.rob_commit, 0);

    // Fill to 16, reject 17th, free via commit, wrap tail
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      issue(6'(i + 1), 0, 0, 0, 32'(i * 4));
      #1;
      chk("fill_new_issue", bus.new_issue, 1);
      chk("fill_tag", bus.rob_new_entry, 32'(i + 1));
      tick();
    end
    idle();
    #1;
    chk("fill_full", bus.rob_full, 1);
    issue(6'd20, 0, 0, 0, 32'h0);
    #1;
    chk("fill_17th_rejected", bus.new_issue, 0);
    chk("fill_wrap_tag", bus.rob_new_entry, 1);
    idle();
    cdb(5'd1, 32'h11, 0, 0);
    tick();
    idle();
    #1;
    chk("full_during_commit", bus.rob_full, 1);
    issue(6'd20, 0, 0, 0, 32'h0);
    #1;
    chk("full_same_cycle_commit", bus.new_issue, 0);
    tick();
    chk("full_commit", bus.rob_commit, 1);
    chk("full_commit_entry", bus.rob_entry, 1);
    chk("full_freed", bus.rob_full, 0);
    chk("full_reissue", bus.new_issue, 1);
    chk("full_reissue_tag", bus.rob_new_entry, 1);
    tick();
    idle();
    #1;
    chk("full_again", bus.rob_full, 1);

    // Out-of-order completion, in-order retirement
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      issue(6'(i + 1), 0, (i == 1), 0, 32'(i * 4));
      tick();
    end
    idle();
    cdb(5'd3, 32'h33, 0, 0);
    tick();
    cdb(5'd2, 32'h22, 0, 0);
    #1;
    chk("ooo_hold_a", bus.rob_commit, 0);
    tick();
    cdb(5'd1, 32'h11, 0, 0);
    #1;
    chk("ooo_hold_b", bus.rob_commit, 0);
    tick();
    idle();
    #1;
    chk("ooo_hold_c", bus.rob_commit, 0);
    tick();
    chk("ooo_c1", bus.rob_commit, 1);
    chk("ooo_c1_entry", bus.rob_entry, 1);
    chk("ooo_c1_result", bus.rob_result, 32'h11);
    tick();
    chk("ooo_c2_entry", bus.rob_entry, 2);
    chk("ooo_c2_result", bus.rob_result, 32'h22);
    chk("ooo_c2_store", bus.store_commit, 1);
    tick();
    chk("ooo_c3_entry", bus.rob_entry, 3);
    chk("ooo_c3_des", bus.rob_des, 3);
    chk("ooo_c3_store", bus.store_commit, 0);
    tick();
    chk("ooo_done", bus.rob_commit, 0);

    // Operand query vectors (combinational, within one cycle)
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      issue(6'(i + 1), 0, 0, 0, 32'h0);
      tick();
    end
    idle();
    cdb(5'd2, 32'h55, 0, 0);
    tick();
    idle();
    for (int i = 0; i < 7; i++) begin
      bus.query_j   = qv[i].qj;
      bus.query_k   = qv[i].qk;
      bus.cdb_valid = qv[i].cv;
      bus.cdb_entry = qv[i].ce;
      bus.cdb_value = qv[i].cval;
      #1;
      chk($sformatf("q%0d_ready_j", i), bus.ready_j, qv[i].rj);
      chk($sformatf("q%0d_value_j", i), bus.value_j, qv[i].vj);
      chk($sformatf("q%0d_ready_k", i), bus.ready_k, qv[i].rk);
      chk($sformatf("q%0d_value_k", i), bus.value_k, qv[i].vk);
    end
    idle();
    tick();

    // Mispredict (taken) with younger entries, flush and one-cycle roll_back
    reset_dut();
    issue(6'd0, 1, 0, 0, 32'h100);
    tick();
    issue(6'd7, 0, 0, 0, 32'h104);
    tick();
    issue(6'd8, 0, 0, 0, 32'h108);
    tick();
    idle();
    cdb(5'd2, 32'h77, 0, 0);
    tick();
    cdb(5'd1, 32'h104, 1, 32'h200);
    tick();
    idle();
    #1;
    chk("mp_no_early_rb", bus.roll_back, 0);
    tick();
    chk("mp_commit", bus.rob_commit, 1);
    chk("mp_commit_entry", bus.rob_entry, 1);
    chk("mp_roll_back", bus.roll_back, 1);
    chk("mp_jump_pc", bus.jump_pc, 32'h200);
    chk("mp_tail_reset", bus.rob_new_entry, 1);
    chk("mp_not_full", bus.rob_full, 0);
    issue(6'd9, 0, 0, 0, 32'h200);
    cdb(5'd3, 32'h88, 0, 0);
    #1;
    chk("mp_issue_blocked", bus.new_issue, 0);
    tick();
    idle();
    chk("mp_rb_pulse", bus.roll_back, 0);
    chk("mp_commit_pulse", bus.rob_commit, 0);
    chk("mp_tail_still0", bus.rob_new_entry, 1);
    issue(6'd9, 0, 0, 0, 32'h200);
    #1;
    chk("mp_issue_after", bus.new_issue, 1);
    tick();
    idle();
    tick();
    chk("mp_young_flushed", bus.rob_commit, 0);
    tick();
    chk("mp_young_flushed2", bus.rob_commit, 0);

    // Mispredict not-taken: redirect to pc+4
    reset_dut();
    issue(6'd0, 1, 0, 1, 32'h300);
    tick();
    idle();
    cdb(5'd1, 32'h0, 0, 32'h999);
    tick();
    idle();
    tick();
    chk("nt_roll_back", bus.roll_back, 1);
    chk("nt_jump_pc", bus.jump_pc, 32'h304);

    // Correctly predicted branch: commit without roll_back
    reset_dut();
    issue(6'd0, 1, 0, 1, 32'h400);
    tick();
    idle();
    cdb(5'd1, 32'h0, 1, 32'h500);
    tick();
    idle();
    tick();
    chk("ok_br_commit", bus.rob_commit, 1);
    chk("ok_br_no_rb", bus.roll_back, 0);

    // Pause: rdy_in low holds a ready head and blocks issue
    reset_dut();
    issue(6'd9, 0, 1, 0, 32'h0);
    tick();
    idle();
    cdb(5'd1, 32'hBEEF, 0, 0);
    tick();
    idle();
    rdy_in = 1'b0;
    issue(6'd10, 0, 0, 0, 32'h4);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pause_no_issue", bus.new_issue, 0);
      tick();
      chk("pause_no_commit", bus.rob_commit, 0);
    end
    chk("pause_tag_held", bus.rob_new_entry, 2);
    rdy_in = 1'b1;
    idle();
    tick();
    chk("pause_commit", bus.rob_commit, 1);
    chk("pause_result", bus.rob_result, 32'hBEEF);
    chk("pause_des", bus.rob_des, 9);
    chk("pause_store", bus.store_commit, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
